gram_adj_det: RTL and testbench

- Front stage of the ZF inverse path. Accepts a 2x2 complex channel matrix H and forms the Gram matrix G = H^H·H.
- Emits the adjugate of G as a packed 4-word vector (vec) and det(G) as a scalar (el). These feed the 4-lane divider directly to produce G^-1.
- Uses one shared signed multiplier with an FSM-sequenced accumulator. H is passed through alongside the results for the later H^H multiply.

---
 rtl/zf_pkg.sv | 63 ++++++
 rtl/mac_unit.sv | 69 ++++++
 rtl/gram_adj_det.sv | 212 +++++++++++++++++++++
 tb/tb_gram_adj_det.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zf_pkg.sv
`default_nettype none
// ============================================================================
// Module : zf_pkg
// Brief  : Shared constants, FSM encoding, field indices and saturating
//          helpers for the ZF inverse path front stage.
// Rev    : 1.0  initial release
// ============================================================================
package zf_pkg;

    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int ACC_W = 2*W + 3;

    localparam logic [W-1:0] c_sat_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_sat_min = {1'b1, {(W-1){1'b0}}};

    typedef logic [1:0] state_t;
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_gram = 2'd1;
    localparam logic [1:0] c_st_det  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Word indices into h_in / h_out (word 7 is the MSB word)
    localparam int c_h11r = 7;
    localparam int c_h11i = 6;
    localparam int c_h12r = 5;
    localparam int c_h12i = 4;
    localparam int c_h21r = 3;
    localparam int c_h21i = 2;
    localparam int c_h22r = 1;
    localparam int c_h22i = 0;

    // Word indices into vec
    localparam int c_vec_g22  = 3;
    localparam int c_vec_ng12r = 2;
    localparam int c_vec_ng12i = 1;
    localparam int c_vec_g11  = 0;

    function automatic logic [W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic [W-1:0]            result;
        shifted = acc >>> FRAC;
        // In range only when every bit above the W-bit sign agrees with it
        if ((&shifted[ACC_W-1:W-1]) || (~|shifted[ACC_W-1:W-1]))
            result = shifted[W-1:0];
        else if (shifted[ACC_W-1])
            result = c_sat_min;
        else
            result = c_sat_max;
        return result;
    endfunction

    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
        logic [W-1:0] result;
        if (x == c_sat_min)
            result = c_sat_max;
        else
            result = (~x) + 1'b1;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module : mac_unit
// Brief  : Shared signed WxW multiplier with registered product, clearable
//          add/subtract accumulator and saturating Q-format rescale.
// Rev    : 1.0  initial release
// ============================================================================
module mac_unit
    import zf_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_enable,
    input  logic                    i_issue,
    input  logic                    i_clr,
    input  logic                    i_sub,
    input  logic [W-1:0]            i_op_a,
    input  logic [W-1:0]            i_op_b,
    output logic                    o_acc_vld,
    output logic [W-1:0]            o_acc_sat
);

    logic signed [2*W-1:0]   w_a_ext;
    logic signed [2*W-1:0]   w_b_ext;
    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;

    logic signed [2*W-1:0]   r_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_vld;
    logic                    r_clr;
    logic                    r_sub;

    always_comb begin
        w_a_ext    = {{W{i_op_a[W-1]}}, i_op_a};
        w_b_ext    = {{W{i_op_b[W-1]}}, i_op_b};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = {{(ACC_W-2*W){r_prod[2*W-1]}}, r_prod};
        w_base     = r_clr ? '0 : r_acc;
        w_sum      = r_sub ? (w_base - w_prod_ext) : (w_base + w_prod_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_vld  <= 1'b0;
            r_clr  <= 1'b0;
            r_sub  <= 1'b0;
        end else if (i_enable) begin
            r_vld <= i_issue;
            if (i_issue) begin
                r_prod <= w_prod;
                r_clr  <= i_clr;
                r_sub  <= i_sub;
            end
            if (r_vld)
                r_acc <= w_sum;
        end
    end

    // Rescaled running sum including the product currently in flight
    assign o_acc_vld = r_vld;
    assign o_acc_sat = sat_shift(w_sum);

endmodule
`default_nettype wire

// File: rtl/gram_adj_det.sv
`default_nettype none
// ============================================================================
// Module : gram_adj_det
// Brief  : Forms G = H^H*H for a 2x2 complex H, emits adj(G) and det(G)
//          using one shared MAC. Optional macro GRAM_SINGULAR_FLAG_EN adds a
//          singular flag and clamps |det| to DET_MIN.
// Rev    : 1.0  initial release
// ============================================================================
module gram_adj_det
    import zf_pkg::*;
`ifdef GRAM_SINGULAR_FLAG_EN
#(
    parameter logic [W-1:0] DET_MIN = 32'h0000_0040
)
`endif
(
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            accept_in,
    output logic            accept_out,
    output logic            ready_out,
    input  logic            down_accept,
    input  logic [8*W-1:0]  h_in,
    output logic [4*W-1:0]  vec,
    output logic [W-1:0]    el,
    output logic [8*W-1:0]  h_out
`ifdef GRAM_SINGULAR_FLAG_EN
    ,
    output logic            singular
`endif
);

    localparam logic [4:0] c_gram_last = 5'd15;
    localparam logic [4:0] c_last_issue = 5'd18;
    localparam logic [4:0] c_last_step = 5'd19;

    state_t         r_state;
    logic [4:0]     r_step;
    logic [8*W-1:0] r_h;
    logic [W-1:0]   r_g11;
    logic [W-1:0]   r_g22;
    logic [W-1:0]   r_g12r;
    logic [W-1:0]   r_g12i;
    logic [4*W-1:0] r_vec;
    logic [W-1:0]   r_el;
    logic           r_ready;
    logic           r_accept;

    logic [W-1:0]   w_hw [8];
    logic [W-1:0]   w_op_a;
    logic [W-1:0]   w_op_b;
    logic           w_clr;
    logic           w_sub;
    logic           w_issue;
    logic           w_acc_vld;
    logic [W-1:0]   w_acc_sat;
    logic [4*W-1:0] w_vec_next;
    logic [W-1:0]   w_el_next;

    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
        assign w_hw[gi] = r_h[gi*W +: W];
    end

    // Product schedule: steps 0-15 build g11, g22, g12r, g12i; 16-18 build det
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        w_clr  = 1'b0;
        w_sub  = 1'b0;
        case (r_step)
            5'd0:  begin w_op_a = w_hw[c_h11r]; w_op_b = w_hw[c_h11r]; w_clr = 1'b1; end
            5'd1:  begin w_op_a = w_hw[c_h11i]; w_op_b = w_hw[c_h11i]; end
            5'd2:  begin w_op_a = w_hw[c_h21r]; w_op_b = w_hw[c_h21r]; end
            5'd3:  begin w_op_a = w_hw[c_h21i]; w_op_b = w_hw[c_h21i]; end
            5'd4:  begin w_op_a = w_hw[c_h12r]; w_op_b = w_hw[c_h12r]; w_clr = 1'b1; end
            5'd5:  begin w_op_a = w_hw[c_h12i]; w_op_b = w_hw[c_h12i]; end
            5'd6:  begin w_op_a = w_hw[c_h22r]; w_op_b = w_hw[c_h22r]; end
            5'd7:  begin w_op_a = w_hw[c_h22i]; w_op_b = w_hw[c_h22i]; end
            5'd8:  begin w_op_a = w_hw[c_h11r]; w_op_b = w_hw[c_h12r]; w_clr = 1'b1; end
            5'd9:  begin w_op_a = w_hw[c_h11i]; w_op_b = w_hw[c_h12i]; end
            5'd10: begin w_op_a = w_hw[c_h21r]; w_op_b = w_hw[c_h22r]; end
            5'd11: begin w_op_a = w_hw[c_h21i]; w_op_b = w_hw[c_h22i]; end
            5'd12: begin w_op_a = w_hw[c_h11r]; w_op_b = w_hw[c_h12i]; w_clr = 1'b1; end
            5'd13: begin w_op_a = w_hw[c_h11i]; w_op_b = w_hw[c_h12r]; w_sub = 1'b1; end
            5'd14: begin w_op_a = w_hw[c_h21r]; w_op_b = w_hw[c_h22i]; end
            5'd15: begin w_op_a = w_hw[c_h21i]; w_op_b = w_hw[c_h22r]; w_sub = 1'b1; end
            5'd16: begin w_op_a = r_g11;  w_op_b = r_g22;  w_clr = 1'b1; end
            5'd17: begin w_op_a = r_g12r; w_op_b = r_g12r; w_sub = 1'b1; end
            5'd18: begin w_op_a = r_g12i; w_op_b = r_g12i; w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_issue = ((r_state == c_st_gram) || (r_state == c_st_det)) &&
                     (r_step <= c_last_issue);

    mac_unit u_mac (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (enable),
        .i_issue   (w_issue),
        .i_clr     (w_clr),
        .i_sub     (w_sub),
        .i_op_a    (w_op_a),
        .i_op_b    (w_op_b),
        .o_acc_vld (w_acc_vld),
        .o_acc_sat (w_acc_sat)
    );

    always_comb begin
        w_vec_next = '0;
        w_vec_next[c_vec_g22*W   +: W] = r_g22;
        w_vec_next[c_vec_ng12r*W +: W] = neg_sat(r_g12r);
        w_vec_next[c_vec_ng12i*W +: W] = neg_sat(r_g12i);
        w_vec_next[c_vec_g11*W   +: W] = r_g11;
    end

`ifdef GRAM_SINGULAR_FLAG_EN
    logic [W-1:0] w_det_mag;
    logic         w_sing_next;
    logic         r_singular;

    always_comb begin
        w_det_mag   = w_acc_sat[W-1] ? neg_sat(w_acc_sat) : w_acc_sat;
        w_sing_next = (w_det_mag < DET_MIN);
        w_el_next   = w_acc_sat;
        if (w_sing_next)
            w_el_next = w_acc_sat[W-1] ? ((~DET_MIN) + 1'b1) : DET_MIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_singular <= 1'b0;
        else if (enable && (r_state == c_st_det) && (r_step == c_last_step))
            r_singular <= w_sing_next;
    end

    assign singular = r_singular;
`else
    assign w_el_next = w_acc_sat;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_step   <= '0;
            r_h      <= '0;
            r_g11    <= '0;
            r_g22    <= '0;
            r_g12r   <= '0;
            r_g12i   <= '0;
            r_vec    <= '0;
            r_el     <= '0;
            r_ready  <= 1'b0;
            r_accept <= 1'b1;
        end else if (enable) begin
            // Each group completes one step after its fourth product issues
            if (w_acc_vld) begin
                case (r_step)
                    5'd4:  r_g11  <= w_acc_sat;
                    5'd8:  r_g22  <= w_acc_sat;
                    5'd12: r_g12r <= w_acc_sat;
                    5'd16: r_g12i <= w_acc_sat;
                    default: ;
                endcase
            end
            case (r_state)
                c_st_idle: begin
                    if (accept_in) begin
                        r_h      <= h_in;
                        r_accept <= 1'b0;
                        r_step   <= '0;
                        r_state  <= c_st_gram;
                    end
                end
                c_st_gram: begin
                    r_step <= r_step + 5'd1;
                    if (r_step == c_gram_last)
                        r_state <= c_st_det;
                end
                c_st_det: begin
                    // Three det products plus one drain step for the product register
                    if (r_step == c_last_step) begin
                        r_vec   <= w_vec_next;
                        r_el    <= w_el_next;
                        r_ready <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_step <= r_step + 5'd1;
                    end
                end
                c_st_done: begin
                    if (down_accept) begin
                        r_ready  <= 1'b0;
                        r_accept <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign accept_out = r_accept;
    assign ready_out  = r_ready;
    assign vec        = r_vec;
    assign el         = r_el;
    assign h_out      = r_h;

endmodule
`default_nettype wire

// File: tb/tb_gram_adj_det.sv
`default_nettype none
// ============================================================================
// Module : tb_gram_adj_det
// Brief  : Scoreboard bench for gram_adj_det with directed matrices.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gram_adj_det;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         accept_in;
    logic         accept_out;
    logic         ready_out;
    logic         down_accept;
    logic [255:0] h_in;
    logic [127:0] vec;
    logic [31:0]  el;
    logic [255:0] h_out;
    logic         singular_w;

    gram_adj_det dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .accept_in   (accept_in),
        .accept_out  (accept_out),
        .ready_out   (ready_out),
        .down_accept (down_accept),
        .h_in        (h_in),
        .vec         (vec),
        .el          (el),
        .h_out       (h_out)
`ifdef GRAM_SINGULAR_FLAG_EN
        ,
        .singular    (singular_w)
`endif
    );

`ifndef GRAM_SINGULAR_FLAG_EN
    assign singular_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] vec;
        logic [31:0]  el;
        logic         sing;
        logic [255:0] h;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_ready = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mkh(input logic [31:0] a, b, c, d, e, f, g, h);
        return {a, b, c, d, e, f, g, h};
    endfunction

    // Monitor: pop and compare on every rising ready_out
    always @(negedge clk) begin
        if (ready_out && !prev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 256'd1, 256'd0);
            end else begin
                mon_e = sb.pop_front();
                check("vec", 256'(vec), 256'(mon_e.vec));
                check("el", 256'(el), 256'(mon_e.el));
                check("h_out", h_out, mon_e.h);
                check("latency_cycle", 256'(cyc), 256'(mon_e.due));
`ifdef GRAM_SINGULAR_FLAG_EN
                check("singular", 256'(singular_w), 256'(mon_e.sing));
`endif
            end
        end
        prev_ready = ready_out;
    end

    task automatic send(input logic [255:0] h, input logic [127:0] v, input logic [31:0] e_el,
                        input logic s, input int lat, input bit push);
        exp_t e;
        int   budget;
        budget = 0;
        @(negedge clk);
        while (!accept_out && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!accept_out) check("accept_timeout", 256'd0, 256'd1);
        h_in      = h;
        accept_in = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.vec = v; e.el = e_el; e.sing = s; e.h = h; e.due = cyc + lat;
            sb.push_back(e);
        end
        accept_in = 1'b0;
    endtask

    task automatic wait_ready();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!ready_out && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (!ready_out) check("ready_timeout", 256'd0, 256'd1);
    endtask

    task automatic finish_one();
        wait_ready();
        down_accept = 1'b1;
        @(posedge clk);
        #1;
        down_accept = 1'b0;
    endtask

    localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef GRAM_SINGULAR_FLAG_EN
    localparam logic [31:0] EL3 = 32'h0000_0040;
    localparam logic        S3  = 1'b1;
`else
    localparam logic [31:0] EL3 = 32'h0;
    localparam logic        S3  = 1'b0;
`endif

    logic [255:0] H1, H2, H3, H4, H5, H6;

    initial begin
        H1 = mkh(ONE, 0, 0, 0, 0, 0, ONE, 0);
        H2 = mkh(32'h0002_0000, 0, ONE, 0, 0, 0, ONE, 0);
        H3 = mkh(0, ONE, ONE, 0, 0, 0, 0, 0);
        H4 = mkh(32'h00C8_0000, 0, 0, 0, 0, 0, ONE, 0);
        H5 = mkh(32'h00C8_0000, 0, 32'hFF38_0000, 0, 0, 0, 0, 0);
        H6 = mkh(ONE, ONE, 32'h0002_0000, 0, 0, ONE, ONE, 32'hFFFF_0000);

        reset = 1'b1; enable = 1'b1; accept_in = 1'b0; down_accept = 1'b0; h_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_accept_out", 256'(accept_out), 256'd1);
        check("rst_ready_out", 256'(ready_out), 256'd0);
        check("rst_vec", 256'(vec), 256'd0);
        check("rst_el", 256'(el), 256'd0);
        check("rst_h_out", h_out, 256'd0);
        reset = 1'b0;

        // Identity
        send(H1, {ONE, 32'h0, 32'h0, ONE}, ONE, 1'b0, 20, 1'b1);
        finish_one();

        // Real H with 10 cycles of backpressure and ignored accept_in
        send(H2, {32'h0002_0000, 32'hFFFE_0000, 32'h0, 32'h0004_0000}, 32'h0004_0000, 1'b0, 20, 1'b1);
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            check("bp_ready", 256'(ready_out), 256'd1);
            check("bp_accept_out", 256'(accept_out), 256'd0);
            check("bp_vec", 256'(vec), 256'({32'h0002_0000, 32'hFFFE_0000, 32'h0, 32'h0004_0000}));
            check("bp_el", 256'(el), 256'(32'h0004_0000));
            accept_in = 1'b1;
            h_in      = H5;
            @(negedge clk);
        end
        accept_in   = 1'b0;
        down_accept = 1'b1;
        @(posedge clk);
        #1;
        down_accept = 1'b0;
        @(negedge clk);
        check("release_ready", 256'(ready_out), 256'd0);
        check("release_accept_out", 256'(accept_out), 256'd1);
        check("release_h_out", h_out, H2);

        // Complex H, then simultaneous down_accept and accept_in in DONE
        send(H3, {ONE, 32'h0, ONE, ONE}, EL3, S3, 20, 1'b1);
        wait_ready();
        down_accept = 1'b1;
        accept_in   = 1'b1;
        h_in        = H4;
        @(posedge clk);
        #1;
        down_accept = 1'b0;
        @(negedge clk);
        check("simul_accept_out", 256'(accept_out), 256'd1);
        check("simul_h_out", h_out, H3);
        @(posedge clk);
        #1;
        mon_e.vec = {ONE, 32'h0, 32'h0, 32'h7FFF_FFFF};
        mon_e.el = 32'h7FFF_FFFF; mon_e.sing = 1'b0; mon_e.h = H4; mon_e.due = cyc + 20;
        sb.push_back(mon_e);
        accept_in = 1'b0;
        finish_one();

        // Negative saturation of g12r and its negation
        send(H5, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF}, 32'hFFFF_0000, 1'b0, 20, 1'b1);
        finish_one();

        // General complex H with a 5-cycle enable stall mid-GRAM
        send(H6, {32'h0006_0000, 32'hFFFF_0000, 32'h0003_0000, 32'h0003_0000}, 32'h0008_0000, 1'b0, 25, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
        finish_one();

        // Reset at cycle 8 of a computation
        send(H6, '0, '0, 1'b0, 0, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_accept_out", 256'(accept_out), 256'd1);
        check("midrst_ready_out", 256'(ready_out), 256'd0);
        check("midrst_vec", 256'(vec), 256'd0);
        check("midrst_el", 256'(el), 256'd0);
        check("midrst_h_out", h_out, 256'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_no_ready", 256'(ready_out), 256'd0);

        // Recovery after reset
        send(H1, {ONE, 32'h0, 32'h0, ONE}, ONE, 1'b0, 20, 1'b1);
        finish_one();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 256'(sb.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
